// File: rtl/rv32m_mul_ctrl.sv
// Sequencing controller between the EX stage and the RV32M multiplier datapath.
// Ports (clk_i, rst_ni async active-low):
//   req_*_i / req_ready_o : one MUL/MULH/MULHSU/MULHU request at a time
//   flush_i               : cancels the in-flight op, no response produced
//   mul_a_o, mul_b_o, mul_signed_o, mul_high_o, mul_result_i : multiplier link
//   rsp_valid_o/rsp_ready_i, rsp_data_o, rsp_rd_o : registered result handshake
//   busy_o                : high whenever the controller is not idle
module rv32m_mul_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_signed_o,
    output logic        mul_high_o,
    input  logic [31:0] mul_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [4:0]  rsp_rd_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Counter holds at most MUL_LAT-1; keep at least one bit.
    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        (MUL_LAT > 0) ? CW'(MUL_LAT - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          sgn_q, sgn_d;
    logic          hi_q, hi_d;
    logic [31:0]   corr_q, corr_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;
    logic [4:0]    rsp_rd_q, rsp_rd_d;

    logic          accept;
    logic          capture;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) state_d = ISSUE;
                end
                ISSUE: begin
                    state_d = (MUL_LAT == 0) ? DONE : WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_d = DONE;
                end
                DONE: begin
                    if (rsp_ready_i) state_d = accept ? ISSUE : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy_o      = (state_q != IDLE);
        rsp_valid_o = (state_q == DONE);
        req_ready_o = ~flush_i &
                      ((state_q == IDLE) |
                       ((state_q == DONE) & rsp_ready_i));
    end

    assign accept  = req_valid_i & req_ready_o;

    // Result is sampled on the last wait cycle, or in ISSUE
    // when the multiplier is purely combinational.
    assign capture = ~flush_i &
                     (((state_q == ISSUE) & (MUL_LAT == 0)) |
                      ((state_q == WAIT) & (cnt_q == '0)));

    // ---------------- datapath next-state ----------------
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        hi_d     = hi_q;
        corr_d   = corr_q;
        rd_d     = rd_q;
        data_d   = data_q;
        rsp_rd_d = rsp_rd_q;
        cnt_d    = cnt_q;

        if (accept) begin
            a_d  = req_rs1_i;
            b_d  = req_rs2_i;
            rd_d = req_rd_i;
            unique case (req_op_i)
                OP_MUL: begin
                    sgn_d  = 1'b0;
                    hi_d   = 1'b0;
                    corr_d = '0;
                end
                OP_MULH: begin
                    sgn_d  = 1'b1;
                    hi_d   = 1'b1;
                    corr_d = '0;
                end
                OP_MULHSU: begin
                    // Run as unsigned-high; a negative rs1 contributes
                    // an extra rs2*2^32 that is subtracted afterwards.
                    sgn_d  = 1'b0;
                    hi_d   = 1'b1;
                    corr_d = req_rs1_i[31] ? req_rs2_i : 32'd0;
                end
                OP_MULHU: begin
                    sgn_d  = 1'b0;
                    hi_d   = 1'b1;
                    corr_d = '0;
                end
                default: begin
                    sgn_d  = 1'b0;
                    hi_d   = 1'b0;
                    corr_d = '0;
                end
            endcase
        end

        if (flush_i) begin
            cnt_d = '0;
        end else if (state_q == ISSUE) begin
            cnt_d = CNT_INIT;
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (capture) begin
            data_d   = mul_result_i - corr_q;
            rsp_rd_d = rd_q;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            hi_q     <= 1'b0;
            corr_q   <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            rsp_rd_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            hi_q     <= hi_d;
            corr_q   <= corr_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

    assign mul_a_o      = a_q;
    assign mul_b_o      = b_q;
    assign mul_signed_o = sgn_q;
    assign mul_high_o   = hi_q;
    assign rsp_data_o   = data_q;
    assign rsp_rd_o     = rsp_rd_q;

endmodule
